// File: rtl/sf_pkg.sv
// Shared encodings for the match controller: FSM state values and the
// finish / match_winner codes exchanged with the game core and display.
package sf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INTRO     = 3'd1,
    ST_FIGHT     = 3'd2,
    ST_ROUND_END = 3'd3,
    ST_MATCH_END = 3'd4
  } state_t;

  localparam logic [1:0] FIN_NONE = 2'b00;
  localparam logic [1:0] FIN_P1   = 2'b01;
  localparam logic [1:0] FIN_P2   = 2'b10;
  localparam logic [1:0] FIN_DRAW = 2'b11;

endpackage

// File: rtl/match_controller_if.sv
// Signal bundle between the game side (master) and match_controller (slave).
// No valid/ready handshake: start is a level sampled for rising edges, finish is
// sampled every cycle while a round is being fought.
interface match_controller_if;
  logic       start;
  logic [1:0] finish;
  logic [3:0] p1_health;
  logic [3:0] p2_health;
  logic       round_rst_l;
  logic       round_active;
  logic [3:0] round_num;
  logic [2:0] p1_wins;
  logic [2:0] p2_wins;
  logic [6:0] timer_s;
  logic [1:0] match_winner;
  logic [2:0] state;

  modport master (
    output start, finish, p1_health, p2_health,
    input  round_rst_l, round_active, round_num, p1_wins, p2_wins,
           timer_s, match_winner, state
  );

  modport slave (
    input  start, finish, p1_health, p2_health,
    output round_rst_l, round_active, round_num, p1_wins, p2_wins,
           timer_s, match_winner, state
  );
endinterface

// File: rtl/match_controller_sec_tick.sv
// One-second tick generator: pulses tick for one cycle every CLK_HZ cycles;
// clr restarts the count so the next second is full length.
module sec_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)           cnt_q <= '0;
    else if (clr || tick) cnt_q <= '0;
    else                  cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/match_controller.sv
// Fighting-game match sequencer: intro countdown, fight timer, round scoring and
// match decision. Define SUDDEN_DEATH_EN to add a tie-break round after MAX_ROUNDS.
module match_controller
  import sf_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int MAX_ROUNDS    = 5,
  parameter int ROUND_TIME_S  = 99,
  parameter int INTRO_S       = 3,
  parameter int END_S         = 2
) (
  input logic              clk,
  input logic              rst_l,
  match_controller_if.slave mc
);

  localparam logic [6:0] ROUND_T = 7'(ROUND_TIME_S);
  localparam logic [6:0] INTRO_T = 7'(INTRO_S);
  localparam logic [6:0] END_T   = 7'(END_S);
  localparam logic [2:0] WIN_T   = 3'(ROUNDS_TO_WIN);
  localparam logic [3:0] MAX_R   = 4'(MAX_ROUNDS);

  state_t     state_q, state_d;
  logic       start_q;
  logic       round_rst_l_q, round_rst_l_d;
  logic       round_active_q, round_active_d;
  logic [3:0] round_num_q, round_num_d;
  logic [2:0] p1_wins_q, p1_wins_d, p2_wins_q, p2_wins_d;
  logic [6:0] timer_q, timer_d;
  logic [6:0] hold_q, hold_d;
  logic [1:0] winner_q, winner_d;
  logic       start_edge, tick, tick_clr;

  assign start_edge = mc.start && !start_q;
  // Restart the second counter on every state change so each state's first second is whole.
  assign tick_clr   = (state_d != state_q);

  sec_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst_l(rst_l),
    .clr  (tick_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q        <= ST_IDLE;
      start_q        <= 1'b1;
      round_rst_l_q  <= 1'b0;
      round_active_q <= 1'b0;
      round_num_q    <= '0;
      p1_wins_q      <= '0;
      p2_wins_q      <= '0;
      timer_q        <= '0;
      hold_q         <= '0;
      winner_q       <= FIN_NONE;
    end else begin
      state_q        <= state_d;
      start_q        <= mc.start;
      round_rst_l_q  <= round_rst_l_d;
      round_active_q <= round_active_d;
      round_num_q    <= round_num_d;
      p1_wins_q      <= p1_wins_d;
      p2_wins_q      <= p2_wins_d;
      timer_q        <= timer_d;
      hold_q         <= hold_d;
      winner_q       <= winner_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    round_num_d = round_num_q;
    p1_wins_d   = p1_wins_q;
    p2_wins_d   = p2_wins_q;
    timer_d     = timer_q;
    hold_d      = hold_q;
    winner_d    = winner_q;
    case (state_q)
      ST_IDLE, ST_MATCH_END: begin
        if (start_edge) begin
          state_d     = ST_INTRO;
          round_num_d = 4'd1;
          p1_wins_d   = '0;
          p2_wins_d   = '0;
          winner_d    = FIN_NONE;
          timer_d     = INTRO_T;
        end
      end
      ST_INTRO: begin
        if (tick) begin
          if (timer_q <= 7'd1) begin
            state_d = ST_FIGHT;
            timer_d = ROUND_T;
          end else begin
            timer_d = timer_q - 7'd1;
          end
        end
      end
      ST_FIGHT: begin
        // A reported finish outranks a timeout landing in the same cycle.
        if (mc.finish != FIN_NONE) begin
          state_d = ST_ROUND_END;
          hold_d  = END_T;
          if (mc.finish == FIN_P1)      p1_wins_d = p1_wins_q + 3'd1;
          else if (mc.finish == FIN_P2) p2_wins_d = p2_wins_q + 3'd1;
        end else if (tick) begin
          if (timer_q <= 7'd1) begin
            timer_d = '0;
            state_d = ST_ROUND_END;
            hold_d  = END_T;
            if (mc.p1_health > mc.p2_health)      p1_wins_d = p1_wins_q + 3'd1;
            else if (mc.p2_health > mc.p1_health) p2_wins_d = p2_wins_q + 3'd1;
          end else begin
            timer_d = timer_q - 7'd1;
          end
        end
      end
      ST_ROUND_END: begin
        if (tick) begin
          if (hold_q > 7'd1) begin
            hold_d = hold_q - 7'd1;
          end else if (p1_wins_q == WIN_T) begin
            state_d  = ST_MATCH_END;
            winner_d = FIN_P1;
          end else if (p2_wins_q == WIN_T) begin
            state_d  = ST_MATCH_END;
            winner_d = FIN_P2;
          end else if (round_num_q >= MAX_R) begin
            if (p1_wins_q > p2_wins_q) begin
              state_d  = ST_MATCH_END;
              winner_d = FIN_P1;
            end else if (p2_wins_q > p1_wins_q) begin
              state_d  = ST_MATCH_END;
              winner_d = FIN_P2;
`ifdef SUDDEN_DEATH_EN
            end else if (round_num_q == MAX_R) begin
              state_d     = ST_INTRO;
              round_num_d = round_num_q + 4'd1;
              timer_d     = INTRO_T;
`endif
            end else begin
              state_d  = ST_MATCH_END;
              winner_d = FIN_DRAW;
            end
          end else begin
            state_d     = ST_INTRO;
            round_num_d = round_num_q + 4'd1;
            timer_d     = INTRO_T;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    round_active_d = (state_d == ST_FIGHT);
    round_rst_l_d  = (state_d == ST_FIGHT) || (state_d == ST_ROUND_END) ||
                     (state_d == ST_MATCH_END);
  end

  assign mc.round_rst_l  = round_rst_l_q;
  assign mc.round_active = round_active_q;
  assign mc.round_num    = round_num_q;
  assign mc.p1_wins      = p1_wins_q;
  assign mc.p2_wins      = p2_wins_q;
  assign mc.timer_s      = timer_q;
  assign mc.match_winner = winner_q;
  assign mc.state        = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with a 10-cycle second; builds with or
// without SUDDEN_DEATH_EN and adjusts the tie-break expectations accordingly.
module tb_match_controller;
  import sf_pkg::*;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n;
  logic [1:0] exp_q[$];
  logic [1:0] exp_w;

  match_controller_if mc();

  match_controller #(
    .CLK_HZ(10), .ROUNDS_TO_WIN(2), .MAX_ROUNDS(3),
    .ROUND_TIME_S(5), .INTRO_S(3), .END_S(2)
  ) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .mc   (mc)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag,
                            output int cycles);
    cycles = 0;
    while (mc.state !== s && cycles < budget) begin
      step(1);
      cycles++;
    end
    chk({tag, "_reached"}, mc.state, s);
  endtask

  task automatic pulse_start;
    mc.start = 1'b0;
    step(1);
    mc.start = 1'b1;
    step(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, mc.state, ST_IDLE);
    chk({tag, "_rrst"}, mc.round_rst_l, 1'b0);
    chk({tag, "_ract"}, mc.round_active, 1'b0);
    chk({tag, "_rnum"}, mc.round_num, 4'd0);
    chk({tag, "_p1w"}, mc.p1_wins, 3'd0);
    chk({tag, "_p2w"}, mc.p2_wins, 3'd0);
    chk({tag, "_timer"}, mc.timer_s, 7'd0);
    chk({tag, "_win"}, mc.match_winner, FIN_NONE);
  endtask

  // scoreboard: expected winners queued per match, popped at MATCH_END
  task automatic check_winner(input string tag);
    exp_w = exp_q.pop_front();
    chk(tag, mc.match_winner, exp_w);
  endtask

  initial begin
    mc.start = 1'b0;
    mc.finish = FIN_NONE;
    mc.p1_health = 4'd0;
    mc.p2_health = 4'd0;
    step(3);
    check_reset_outputs("rst");
    rst_l = 1'b1;
    step(2);
    chk("idle_hold", mc.state, ST_IDLE);

    // Match 1: intro timing, P1 takes two rounds by finish
    exp_q.push_back(FIN_P1);
    mc.start = 1'b1;
    step(1);
    mc.start = 1'b0;
    chk("m1_intro", mc.state, ST_INTRO);
    chk("m1_t3", mc.timer_s, 7'd3);
    chk("m1_rnum1", mc.round_num, 4'd1);
    chk("m1_rrst_intro", mc.round_rst_l, 1'b0);
    step(9);
    chk("m1_t3_hold", mc.timer_s, 7'd3);
    step(1);
    chk("m1_t2", mc.timer_s, 7'd2);
    step(10);
    chk("m1_t1", mc.timer_s, 7'd1);
    step(9);
    chk("m1_still_intro", mc.state, ST_INTRO);
    step(1);
    chk("m1_fight", mc.state, ST_FIGHT);
    chk("m1_t5", mc.timer_s, 7'd5);
    chk("m1_rrst_fight", mc.round_rst_l, 1'b1);
    chk("m1_ract", mc.round_active, 1'b1);
    mc.finish = FIN_P1;
    step(1);
    mc.finish = FIN_P2;
    chk("m1_r1_end", mc.state, ST_ROUND_END);
    chk("m1_r1_p1w", mc.p1_wins, 3'd1);
    chk("m1_r1_ract", mc.round_active, 1'b0);
    chk("m1_r1_frozen", mc.timer_s, 7'd5);
    step(1);
    mc.finish = FIN_NONE;
    chk("m1_fin_ignored", mc.p2_wins, 3'd0);
    wait_state(ST_INTRO, 40, "m1_r2_intro", n);
    chk("m1_hold_cyc", n, 19);
    chk("m1_rnum2", mc.round_num, 4'd2);
    wait_state(ST_FIGHT, 60, "m1_r2_fight", n);
    chk("m1_intro_cyc", n, 30);
    mc.finish = FIN_P1;
    step(1);
    mc.finish = FIN_NONE;
    chk("m1_r2_p1w", mc.p1_wins, 3'd2);
    wait_state(ST_MATCH_END, 40, "m1_mend", n);
    chk("m1_mend_cyc", n, 20);
    check_winner("m1_winner");
    chk("m1_rnum_end", mc.round_num, 4'd2);
    chk("m1_ract_end", mc.round_active, 1'b0);
    step(5);
    chk("m1_mend_hold", mc.state, ST_MATCH_END);

    // Match 2: timeouts by health, then finish colliding with the timeout tick
    exp_q.push_back(FIN_P2);
    mc.start = 1'b1;
    step(1);
    chk("m2_intro", mc.state, ST_INTRO);
    chk("m2_wins_clr", mc.p1_wins, 3'd0);
    chk("m2_winner_clr", mc.match_winner, FIN_NONE);
    chk("m2_rnum1", mc.round_num, 4'd1);
    wait_state(ST_FIGHT, 60, "m2_r1_fight", n);
    chk("m2_intro_cyc", n, 30);
    mc.p1_health = 4'd3;
    mc.p2_health = 4'd7;
    wait_state(ST_ROUND_END, 80, "m2_r1_to", n);
    chk("m2_to_cyc", n, 50);
    chk("m2_r1_p2w", mc.p2_wins, 3'd1);
    chk("m2_r1_p1w", mc.p1_wins, 3'd0);
    chk("m2_r1_timer0", mc.timer_s, 7'd0);
    mc.p1_health = 4'd5;
    mc.p2_health = 4'd5;
    wait_state(ST_FIGHT, 80, "m2_r2_fight", n);
    wait_state(ST_ROUND_END, 80, "m2_r2_to", n);
    chk("m2_r2_cyc", n, 50);
    chk("m2_r2_p2w", mc.p2_wins, 3'd1);
    chk("m2_r2_p1w", mc.p1_wins, 3'd0);
    wait_state(ST_FIGHT, 80, "m2_r3_fight", n);
    mc.p1_health = 4'd9;
    mc.p2_health = 4'd2;
    step(49);
    chk("m2_r3_pre", mc.state, ST_FIGHT);
    chk("m2_r3_t1", mc.timer_s, 7'd1);
    mc.finish = FIN_P2;
    step(1);
    mc.finish = FIN_NONE;
    chk("m2_r3_end", mc.state, ST_ROUND_END);
    chk("m2_r3_p2w", mc.p2_wins, 3'd2);
    chk("m2_r3_no_p1", mc.p1_wins, 3'd0);
    wait_state(ST_MATCH_END, 40, "m2_mend", n);
    check_winner("m2_winner");
    chk("m2_rnum_end", mc.round_num, 4'd3);
    step(5);
    chk("m2_level_start", mc.state, ST_MATCH_END);

    // Match 3: three double KOs
`ifdef SUDDEN_DEATH_EN
    exp_q.push_back(FIN_P1);
`else
    exp_q.push_back(FIN_DRAW);
`endif
    pulse_start();
    mc.start = 1'b0;
    chk("m3_intro", mc.state, ST_INTRO);
    for (int r = 1; r <= 3; r++) begin
      wait_state(ST_FIGHT, 80, "m3_fight", n);
      mc.finish = FIN_DRAW;
      step(1);
      mc.finish = FIN_NONE;
      chk("m3_rend", mc.state, ST_ROUND_END);
      chk("m3_p1w", mc.p1_wins, 3'd0);
      chk("m3_p2w", mc.p2_wins, 3'd0);
    end
`ifdef SUDDEN_DEATH_EN
    wait_state(ST_INTRO, 40, "m3_sd_intro", n);
    chk("m3_sd_rnum", mc.round_num, 4'd4);
    wait_state(ST_FIGHT, 60, "m3_sd_fight", n);
    mc.finish = FIN_P1;
    step(1);
    mc.finish = FIN_NONE;
    wait_state(ST_MATCH_END, 40, "m3_mend", n);
    chk("m3_sd_p1w", mc.p1_wins, 3'd1);
    chk("m3_rnum_end", mc.round_num, 4'd4);
`else
    wait_state(ST_MATCH_END, 40, "m3_mend", n);
    chk("m3_rnum_end", mc.round_num, 4'd3);
`endif
    check_winner("m3_winner");

    // Reset mid-fight with start held high across it
    pulse_start();
    wait_state(ST_FIGHT, 60, "m4_fight", n);
    step(3);
    #2;
    rst_l = 1'b0;
    #1;
    check_reset_outputs("m4_async");
    step(3);
    rst_l = 1'b1;
    step(5);
    chk("m4_no_resume", mc.state, ST_IDLE);
    chk("m4_rnum0", mc.round_num, 4'd0);
    pulse_start();
    mc.start = 1'b0;
    chk("m4_restart", mc.state, ST_INTRO);
    chk("m4_restart_rnum", mc.round_num, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, clock cycles per one-second tick.
REQ-002 Parameter ROUNDS_TO_WIN, default 2, round wins needed to take the match (1..7).
REQ-003 Parameter MAX_ROUNDS, default 5, round cap per match (ROUNDS_TO_WIN*2-1 .. 14).
REQ-004 Parameter ROUND_TIME_S, default 99, fight timer start value in seconds (1..127).
REQ-005 Parameter INTRO_S, default 3, pre-fight countdown seconds (1..127); END_S, default 2, post-round hold seconds (1..127).
REQ-006 clk  in  1  system clock; the block has exactly one clock.
REQ-007 rst_l  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  synchronous level; its rising edge starts a match.
REQ-009 finish  in  2  from game core: 00 none, 01 P1 won, 10 P2 won, 11 double KO.
REQ-010 p1_health, p2_health  in  4 each  current health, used for timeout decisions.
REQ-011 round_rst_l  out  1  active-low reset to game core.
REQ-012 round_active  out  1  high only in FIGHT.
REQ-013 round_num  out  4  current round, 1-based; 0 in IDLE.
REQ-014 p1_wins, p2_wins  out  3 each  rounds won this match.
REQ-015 timer_s  out  7  displayed seconds value.
REQ-016 match_winner  out  2  00 undecided, 01 P1, 10 P2, 11 draw.
REQ-017 state  out  3  encoded FSM state for display/debug.

Function
REQ-018 FSM states SHALL be IDLE, INTRO, FIGHT, ROUND_END, MATCH_END; all outputs registered.
REQ-019 start edge: rising edge = start high and previous-cycle start low; level-held start SHALL NOT retrigger.
REQ-020 A one-second tick SHALL pulse once per CLK_HZ cycles; its counter SHALL clear on every state entry, so the first second of each state is full length.
REQ-021 IDLE: round_rst_l=0, round_num=0; start edge -> INTRO with wins cleared, round_num=1, match_winner=00.
REQ-022 INTRO: round_rst_l=0, timer_s counts INTRO_S down to 1 on ticks; tick at timer_s=1 -> FIGHT, timer_s=ROUND_TIME_S.
REQ-023 FIGHT: round_rst_l=1, round_active=1; each tick decrements timer_s; timer_s SHALL never wrap below 0.
REQ-024 FIGHT, finish!=00 -> ROUND_END, crediting 01 to P1, 10 to P2, 11 to nobody.
REQ-025 FIGHT, tick while timer_s=1 (timer reaching 0) -> ROUND_END; higher health credited, equal health = draw.
REQ-026 finish!=00 and timeout in the same cycle: finish SHALL take priority.
REQ-027 ROUND_END: round_rst_l=1, round_active=0, timer_s frozen, hold END_S seconds, then evaluate.
REQ-028 Evaluate: a wins counter equal to ROUNDS_TO_WIN -> MATCH_END with that winner; else round_num=MAX_ROUNDS -> MATCH_END with more wins winning, equal = 11; else round_num+1 -> INTRO.
REQ-029 MATCH_END: round_active=0, outputs held; start edge -> INTRO as in REQ-021.
REQ-030 finish SHALL be ignored outside FIGHT; start SHALL be ignored in INTRO, FIGHT, ROUND_END.

Reset
REQ-031 rst_l low SHALL asynchronously force IDLE, round_rst_l=0, round_active=0, round_num=0, wins=0, timer_s=0, match_winner=00, tick counter=0, start history=1.
REQ-032 rst_l deassertion mid-match SHALL NOT resume; a new start edge is required.

Configuration
REQ-033 Macro SUDDEN_DEATH_EN: defined -> tied wins at MAX_ROUNDS enters one extra INTRO/FIGHT round (round_num=MAX_ROUNDS+1) whose win decides the match; a further draw ends it as 11. Undefined -> tie ends at MAX_ROUNDS with 11.

Structure
REQ-034 Shared package sf_pkg SHALL hold the state encoding and the finish/winner codes (FIN_NONE, FIN_P1, FIN_P2, FIN_DRAW).
REQ-035 One sub-module sec_tick (parameter CLK_HZ, sync clear input, one-cycle tick output) SHALL implement REQ-020.

Verification (CLK_HZ=10, INTRO_S=3, END_S=2, ROUND_TIME_S=5, ROUNDS_TO_WIN=2, MAX_ROUNDS=3)
REQ-036 Reset, start pulse -> INTRO, timer_s 3,2,1 at 10-cycle spacing, FIGHT after 30 cycles with timer_s=5, round_rst_l rises.
REQ-037 finish=01 in rounds 1 and 2 -> p1_wins=2, MATCH_END, match_winner=01, round_num=2.
REQ-038 No finish, p1_health=3, p2_health=7 -> timeout after 50 cycles, p2_wins=1; equal health -> no credit.
REQ-039 finish=10 in the timeout cycle -> exactly one P2 credit, no double count.
REQ-040 Three draws, macro undefined -> MATCH_END winner 11; macro defined -> round_num=4, finish=01 -> winner 01.
REQ-041 rst_l low during FIGHT -> immediate IDLE, all outputs at REQ-031 values; start held high across reset -> no match start.
